// File: rtl/seq_mul.sv
// Sequential radix-2 shift-add multiplier: one multiplier bit per cycle on operand
// magnitudes, with the sign applied to the final 2*WIDTH-bit result.
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_next;

    logic [2*WIDTH-1:0] mcand_sh;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [CNT_W-1:0]   cnt;
    logic               last_step;

    // Magnitude as unsigned WIDTH bits; the most-negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    // Two's-complement negation leaves zero at zero.
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m,
                                                      input logic negate);
        return negate ? (~m + (2*WIDTH)'(1)) : m;
    endfunction

    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign acc_next  = acc + (mplier[0] ? mcand_sh : '0);

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_sh <= '0;
            mplier   <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            product  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_sh <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
                        mplier   <= magnitude(b, signed_mode);
                        neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt      <= '0;
                        acc      <= '0;
                    end
                end
                CALC: begin
                    // Final step folds the last partial product straight into the result.
                    acc      <= acc_next;
                    mcand_sh <= mcand_sh << 1;
                    mplier   <= mplier >> 1;
                    cnt      <= cnt + CNT_W'(1);
                    if (last_step) product <= apply_sign(acc_next, neg);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Directed bench for seq_mul: an abstract timing/arithmetic model checked every cycle
// on the 8-bit instance, plus literal expectations on both 8-bit and 4-bit instances.
module tb_seq_mul;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, signed_mode;
    logic [7:0]  a, b;
    logic        busy, done;
    logic [15:0] product;

    logic        start4, signed_mode4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  product4;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    seq_mul #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(signed_mode4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                            input logic sm);
        logic signed [15:0] p;
        if (sm) begin
            p = 16'($signed(x)) * 16'($signed(y));
            return p;
        end
        return 16'(x) * 16'(y);
    endfunction

    // Model: a multiply is accepted when not busy, runs 8 cycles, then shows done for one cycle.
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [15:0] m_prod = '0, m_res = '0;
    int          m_rem = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_prod = '0; m_rem = 0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_prod = m_res;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_busy = 1'b1; m_rem = 8; m_res = ref_mul(a, b, signed_mode);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_done", 32'(done), 32'(m_done));
            check("model_product", 32'(product), 32'(m_prod));
        end
    end

    // Caller sits just after a negedge; returns at the negedge where done is seen.
    task automatic do_op(input string name, input logic [7:0] x, input logic [7:0] y,
                         input logic sm, input logic [15:0] exp);
        int k = 0;
        start = 1'b1; a = x; b = y; signed_mode = sm;
        do begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end while (!done && k < 20);
        check({name, "_latency"}, 32'(k), 32'd9);
        check(name, 32'(product), 32'(exp));
    endtask

    initial begin
        int busy_cnt, done_at, done_cnt, k;
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        start4 = 1'b0; signed_mode4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_product4", 32'(product4), 32'd0);
        chk_en = 1'b1;

        // Start accepted on the very first edge out of reset.
        rst_n = 1'b1;
        do_op("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
        do_op("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
        do_op("s_m128x1", 8'h80, 8'h01, 1'b1, 16'hFF80);
        do_op("s_0xm128", 8'h00, 8'h80, 1'b1, 16'h0000);
        do_op("u_ffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        do_op("u_00xff", 8'h00, 8'hFF, 1'b0, 16'h0000);
        do_op("u_ffx02", 8'hFF, 8'h02, 1'b0, 16'h01FE);
        repeat (5) @(negedge clk);
        check("idle_hold", 32'(product), 32'h01FE);

        // WIDTH=4 unsigned 3*5
        start4 = 1'b1; a4 = 4'b0011; b4 = 4'b0101; signed_mode4 = 1'b0;
        busy_cnt = 0; done_at = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (busy4) busy_cnt++;
            if (done4 && done_at == 0) begin
                done_at = i;
                check("w4_product", 32'(product4), 32'h0F);
            end
        end
        check("w4_busy_cycles", 32'(busy_cnt), 32'd4);
        check("w4_done_cycle", 32'(done_at), 32'd5);

        // Start pulsed through CALC with changing operands
        start = 1'b1; a = 8'h12; b = 8'h34; signed_mode = 1'b0;
        done_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                check("hs_product", 32'(product), 32'h03A8);
            end
            if (i <= 8) begin
                start = 1'b1; a = 8'(i * 17); b = ~8'(i * 17); signed_mode = i[0];
            end else begin
                start = 1'b0;
            end
        end
        check("hs_done_count", 32'(done_cnt), 32'd1);

        // Back-to-back: restart during DONE
        do_op("b2b_first", 8'h07, 8'h09, 1'b0, 16'h003F);
        start = 1'b1; a = 8'h10; b = 8'h10; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        check("b2b_hold", 32'(product), 32'h003F);
        k = 1;
        while (!done && k < 20) begin
            @(negedge clk);
            if (!done) check("b2b_hold_calc", 32'(product), 32'h003F);
            k++;
        end
        check("b2b_latency", 32'(k), 32'd9);
        check("b2b_second", 32'(product), 32'h0100);
        @(negedge clk);

        // Reset and start on the same edge: reset wins
        rst_n = 1'b0; start = 1'b1; a = 8'h03; b = 8'h03;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_product", 32'(product), 32'd0);
        @(negedge clk);
        check("rst_start_busy2", 32'(busy), 32'd0);

        // Reset mid-CALC
        do_op("pre_abort", 8'h0B, 8'h0D, 1'b0, 16'h008F);
        start = 1'b1; a = 8'hFF; b = 8'hFF; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        do_op("after_abort", 8'hFE, 8'h7F, 1'b1, 16'hFF02);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
